// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings, R/W and ACK bit values,
// and the register-write request bundle.
package i2c_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ACK_ADDR = 3'd2;
    localparam logic [2:0] ST_REG      = 3'd3;
    localparam logic [2:0] ST_ACK_REG  = 3'd4;
    localparam logic [2:0] ST_DATA     = 3'd5;
    localparam logic [2:0] ST_ACK_DATA = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;
    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;

    typedef struct packed {
        logic       en;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_req_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus history flop for one bus line.
// Reports the synchronized level and its single-cycle rise/fall events.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // [0],[1] synchronize, [2] holds the previous synchronized level
    logic [2:0] sync_pipe;

    always_ff @(posedge clk) begin
        if (reset) sync_pipe <= 3'b111;
        else       sync_pipe <= {sync_pipe[1:0], din};
    end

    assign level = sync_pipe[1];
    assign rise  = sync_pipe[1] & ~sync_pipe[2];
    assign fall  = ~sync_pipe[1] & sync_pipe[2];

endmodule

// File: rtl/i2c_slave_writer.sv
// Write-only I2C target: receives address, register pointer and data bytes,
// ACKs each accepted byte and emits one register-write strobe per data byte.
module i2c_slave_writer
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [7:0] states
);

    logic       scl_lvl, scl_rise, scl_fall;
    logic       sda_lvl, sda_rise, sda_fall;
    logic [2:0] state, next_state;
    logic [7:0] shift, ptr;
    logic [2:0] bit_cnt;
    logic       byte_full, sda_low, sda_low_nxt, wr_fire;
    logic       start, stop, in_byte, byte_end;
    wr_req_t    wr;

    i2c_line_sync u_scl (.clk(clk), .reset(reset), .din(i2c_scl),
                         .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    i2c_line_sync u_sda (.clk(clk), .reset(reset), .din(i2c_sda),
                         .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

    assign start    = scl_lvl & sda_fall;
    assign stop     = scl_lvl & sda_rise;
    assign in_byte  = (state == ST_ADDR) || (state == ST_REG) || (state == ST_DATA);
    // Byte is acted on at the SCL fall following its 8th rise; bus conditions win
    assign byte_end = in_byte & scl_fall & byte_full & ~start & ~stop;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (stop)       next_state = ST_IDLE;
        else if (start) next_state = ST_ADDR;
        else begin
            case (state)
                ST_ADDR:     if (byte_end)
                                 next_state = (shift[7:1] == DEV_ADDR && shift[0] == I2C_WRITE)
                                              ? ST_ACK_ADDR : ST_IGNORE;
                ST_REG:      if (byte_end) next_state = ST_ACK_REG;
                ST_DATA:     if (byte_end) next_state = ST_ACK_DATA;
                ST_ACK_ADDR: if (scl_fall) next_state = ST_REG;
                ST_ACK_REG,
                ST_ACK_DATA: if (scl_fall) next_state = ST_DATA;
                default:     next_state = state;
            endcase
        end
    end

    always_comb begin
        sda_low_nxt = (next_state == ST_ACK_ADDR) || (next_state == ST_ACK_REG) ||
                      (next_state == ST_ACK_DATA);
        wr_fire     = byte_end && (state == ST_DATA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift     <= 8'h00;
            bit_cnt   <= 3'd7;
            byte_full <= 1'b0;
            ptr       <= 8'h00;
            sda_low   <= 1'b0;
            wr        <= '0;
        end else begin
            sda_low <= sda_low_nxt;
            wr.en   <= wr_fire;
            if (wr_fire) begin
                wr.addr <= ptr;
                wr.data <= shift;
            end
            if (start || stop || byte_end) begin
                bit_cnt   <= 3'd7;
                byte_full <= 1'b0;
            end else if (in_byte && scl_rise && !byte_full) begin
                shift <= {shift[6:0], sda_lvl};
                if (bit_cnt == 3'd0) byte_full <= 1'b1;
                else                 bit_cnt   <= bit_cnt - 3'd1;
            end
            if (byte_end && state == ST_REG) ptr <= shift;
            else if (wr_fire)                ptr <= ptr + 8'd1;
        end
    end

    assign i2c_sda = sda_low ? ACK : 1'bz;
    assign wr_en   = wr.en;
    assign wr_addr = wr.addr;
    assign wr_data = wr.data;
    assign busy    = (state != ST_IDLE) && (state != ST_IGNORE);
    assign states  = {5'd0, state};

endmodule

// File: tb/tb_i2c_slave_writer.sv
// Directed bench: bit-banged I2C master on a pulled-up open-drain SDA line,
// write strobes captured in a queue and checked against hand-computed values.
`timescale 1ns/1ps
module tb_i2c_slave_writer;

    localparam int Q = 40;  // quarter SCL period, 4 clk

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    wire        sda;
    logic       wr_en, busy;
    logic [7:0] wr_addr, wr_data, states;
    logic [15:0] wq[$];
    logic       a;
    int         total = 0;
    int         bad = 0;

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    i2c_slave_writer dut (
        .clk(clk), .reset(reset), .i2c_scl(scl), .i2c_sda(sda),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .states(states)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_en) wq.push_back({wr_addr, wr_data});

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    task automatic bus_start();
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #Q;
    endtask

    task automatic put_bit(input logic b);
        m_sda = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic get_ack(output logic ack);
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; ack = sda; #Q; scl = 1'b0; #Q;
    endtask

    task automatic put_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_ack(ack);
    endtask

    task automatic pop_check(input string tag, input logic [15:0] exp);
        logic [15:0] v;
        v = 16'hdead;
        if (wq.size() > 0) v = wq.pop_front();
        check(tag, v, exp);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("rst_state", {8'h0, states}, 16'h0);
        check("rst_busy", {15'h0, busy}, 16'h0);
        check("rst_wr_en", {15'h0, wr_en}, 16'h0);
        check("rst_wr_addr", {8'h0, wr_addr}, 16'h0);
        check("rst_wr_data", {8'h0, wr_data}, 16'h0);
        check("rst_sda", {15'h0, sda}, 16'h1);
        @(negedge clk) reset = 1'b0;
        #100;

        // plain write 0x50 / reg 0x10 / data 0xAA
        bus_start();
        check("t1_addr_state", {8'h0, states}, 16'h1);
        check("t1_busy", {15'h0, busy}, 16'h1);
        put_byte(8'hA0, a); check("t1_ack_addr", {15'h0, a}, 16'h0);
        put_byte(8'h10, a); check("t1_ack_reg", {15'h0, a}, 16'h0);
        put_byte(8'hAA, a); check("t1_ack_data", {15'h0, a}, 16'h0);
        bus_stop(); #100;
        check("t1_idle", {8'h0, states}, 16'h0);
        check("t1_nwr", wq.size(), 16'd1);
        pop_check("t1_wr", 16'h10AA);
        check("t1_hold", {wr_addr, wr_data}, 16'h10AA);

        // wrong device address
        bus_start();
        put_byte(8'hA2, a); check("t2_nack_addr", {15'h0, a}, 16'h1);
        check("t2_ignore", {8'h0, states}, 16'h7);
        check("t2_busy", {15'h0, busy}, 16'h0);
        put_byte(8'h10, a); check("t2_nack_reg", {15'h0, a}, 16'h1);
        put_byte(8'h55, a); check("t2_nack_data", {15'h0, a}, 16'h1);
        check("t2_still_ignore", {8'h0, states}, 16'h7);
        bus_stop(); #100;
        check("t2_idle", {8'h0, states}, 16'h0);
        check("t2_nwr", wq.size(), 16'd0);

        // read request is refused
        bus_start();
        put_byte(8'hA1, a); check("t3_nack_read", {15'h0, a}, 16'h1);
        check("t3_ignore", {8'h0, states}, 16'h7);
        bus_stop(); #100;
        check("t3_nwr", wq.size(), 16'd0);

        // burst across pointer wrap
        bus_start();
        put_byte(8'hA0, a); check("t4_ack_addr", {15'h0, a}, 16'h0);
        put_byte(8'hFF, a); check("t4_ack_reg", {15'h0, a}, 16'h0);
        put_byte(8'h11, a); check("t4_ack_d0", {15'h0, a}, 16'h0);
        put_byte(8'h22, a); check("t4_ack_d1", {15'h0, a}, 16'h0);
        put_byte(8'h33, a); check("t4_ack_d2", {15'h0, a}, 16'h0);
        bus_stop(); #100;
        check("t4_nwr", wq.size(), 16'd3);
        pop_check("t4_wr0", 16'hFF11);
        pop_check("t4_wr1", 16'h0022);
        pop_check("t4_wr2", 16'h0133);

        // repeated START after a partial data byte
        bus_start();
        put_byte(8'hA0, a);
        put_byte(8'h30, a);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        bus_start();
        check("t5_restart_state", {8'h0, states}, 16'h1);
        put_byte(8'hA0, a); check("t5_ack_addr", {15'h0, a}, 16'h0);
        put_byte(8'h20, a); check("t5_ack_reg", {15'h0, a}, 16'h0);
        put_byte(8'h5A, a); check("t5_ack_data", {15'h0, a}, 16'h0);
        bus_stop(); #100;
        check("t5_nwr", wq.size(), 16'd1);
        pop_check("t5_wr", 16'h205A);

        // reset while the register-byte ACK is being driven
        bus_start();
        put_byte(8'hA0, a);
        for (int i = 7; i >= 0; i--) put_bit(i[0]);
        m_sda = 1'b1; #Q;
        check("t6_ack_reg_state", {8'h0, states}, 16'h4);
        check("t6_sda_low", {15'h0, sda}, 16'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;
        check("t6_sda_released", {15'h0, sda}, 16'h1);
        check("t6_rst_state", {8'h0, states}, 16'h0);
        check("t6_rst_busy", {15'h0, busy}, 16'h0);
        @(negedge clk) reset = 1'b0;
        scl = 1'b1; #100;
        bus_start();
        put_byte(8'hA0, a); check("t6_ack_addr", {15'h0, a}, 16'h0);
        put_byte(8'h60, a); check("t6_ack_reg", {15'h0, a}, 16'h0);
        put_byte(8'h77, a); check("t6_ack_data", {15'h0, a}, 16'h0);
        bus_stop(); #100;
        check("t6_nwr", wq.size(), 16'd1);
        pop_check("t6_wr", 16'h6077);
        check("t6_idle", {8'h0, states}, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
